// File: rtl/booth_iter_mul_if.sv
// Operand/product handshake bundle for booth_iter_mul.
// master = operand producer and product consumer, slave = the multiplier.
interface booth_iter_mul_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, multiplicand, multiplier, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, multiplicand, multiplier, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/booth_iter_mul.sv
// Iterative radix-4 Booth signed multiplier, one Booth digit per clock.
// Define BOOTH_SKIP_ZERO_EN to finish early once the remaining multiplier digits are all zero.
module booth_iter_mul #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  booth_iter_mul_if.slave   bus
);
  localparam int HALF = WIDTH / 2;
  localparam int IW   = $clog2(HALF);
  localparam logic [IW-1:0] LAST_IDX = IW'(HALF - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state;
  state_t               state_next;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [IW-1:0]        idx;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   prod_reg;
  logic [2*WIDTH-1:0]   a_ext;
  logic [2*WIDTH-1:0]   pp;
  logic [WIDTH:0]       b_ext;
  logic [2:0]           window;
  logic                 finish;

  // Window index 2i in b_ext already accounts for the implicit B[-1] = 0.
  always_comb begin
    a_ext  = {{WIDTH{a_reg[WIDTH-1]}}, a_reg};
    b_ext  = {b_reg, 1'b0};
    window = b_ext[{idx, 1'b0} +: 3];
    pp     = '0;
    case (window)
      3'b001, 3'b010: pp = a_ext;
      3'b011:         pp = a_ext << 1;
      3'b100:         pp = -(a_ext << 1);
      3'b101, 3'b110: pp = -a_ext;
      default:        pp = '0;
    endcase
    acc_next = acc + (pp << {idx, 1'b0});
  end

`ifdef BOOTH_SKIP_ZERO_EN
  logic signed [WIDTH-1:0] b_hi;
  logic [IW+1:0]           hi_shift;

  // Remaining digits are all zero when B[WIDTH-1:2i+1] is a pure sign run.
  always_comb begin
    hi_shift = {1'b0, idx, 1'b1};
    b_hi     = $signed(b_reg) >>> hi_shift;
    finish   = (idx == LAST_IDX) || (b_hi == '0) || (b_hi == '1);
  end
`else
  always_comb begin
    finish = (idx == LAST_IDX);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_next = BUSY;
      BUSY:    if (finish)        state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.busy      = (state == BUSY);
  end

  assign bus.product = prod_reg;

  // prod_reg only changes when an operation completes, so it holds outside DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      idx      <= '0;
      acc      <= '0;
      prod_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.multiplicand;
            b_reg <= bus.multiplier;
            acc   <= '0;
            idx   <= '0;
          end
        end
        BUSY: begin
          acc <= acc_next;
          idx <= idx + 1'b1;
          if (finish) prod_reg <= acc_next;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/booth_iter_mul.md
BOOTH_ITER_MUL -- requirements
Module: booth_iter_mul

Interface
- REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; even, >= 4.
- REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
- REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
- REQ-004 SHALL have port in_valid, input, 1, operand pair offered.
- REQ-005 SHALL have port in_ready, output, 1, block can accept an operand pair.
- REQ-006 SHALL have port multiplicand, input, WIDTH, signed two's-complement A.
- REQ-007 SHALL have port multiplier, input, WIDTH, signed two's-complement B.
- REQ-008 SHALL have port out_valid, output, 1, product available.
- REQ-009 SHALL have port out_ready, input, 1, consumer accepts product.
- REQ-010 SHALL have port product, output, 2*WIDTH, signed A*B.
- REQ-011 SHALL have port busy, output, 1, high in BUSY state.

Function
- REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
- REQ-013 SHALL drive in_ready=1 only in IDLE; in_valid outside IDLE is ignored.
- REQ-014 On an edge with in_valid&&in_ready: SHALL latch A and B, clear accumulator, set window index i=0, go to BUSY.
- REQ-015 SHALL ignore multiplicand/multiplier changes after the accept edge.
- REQ-016 Each BUSY edge SHALL take window {B[2i+1],B[2i],B[2i-1]}, with B[-1]=0, and decode it as radix-4 Booth: 000/111 -> 0; 001/010 -> +1; 011 -> +2; 100 -> -2; 101/110 -> -1.
- REQ-017 Each BUSY edge SHALL add digit*A, sign-extended to 2*WIDTH and shifted left 2i, to the accumulator modulo 2^(2*WIDTH), then increment i.
- REQ-018 After the window with i=WIDTH/2-1 SHALL go to DONE; base latency = WIDTH/2 edges from accept edge to out_valid high.
- REQ-019 In DONE SHALL hold out_valid=1 with product = accumulator stable until out_ready=1.
- REQ-020 On an edge with out_valid&&out_ready SHALL go to IDLE; a new accept is possible no earlier than the following edge.
- REQ-021 product SHALL equal the exact signed product for all inputs, including A=B=-2^(WIDTH-1).
- REQ-022 out_valid SHALL be 0 in IDLE and BUSY; product SHALL hold its last value outside DONE.

Reset
- REQ-023 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, busy=0, product=0, accumulator=0, i=0.
- REQ-024 Reset during BUSY or DONE SHALL abandon the operation with no product delivered.
- REQ-025 After rst_n deasserts, an accept SHALL be possible on the first rising edge.

Configuration
- REQ-026 Macro BOOTH_SKIP_ZERO_EN defined: after each BUSY window i, if B[WIDTH-1:2i+1] are all equal, all remaining digits are 0, so the block SHALL go to DONE at that edge; latency = windows processed, minimum 1.
- REQ-027 Macro BOOTH_SKIP_ZERO_EN undefined: the block SHALL always process exactly WIDTH/2 windows; product values SHALL be identical in both builds.

Verification (WIDTH=16)
- REQ-028 A=3, B=5 -> product=0x0000000F; out_valid 8 edges after accept without the macro, 2 edges after accept with it.
- REQ-029 A=-32768, B=-32768 -> product=0x40000000; A=32767, B=-32768 -> product=0xC0008000.
- REQ-030 A=-7, B=1 -> product=0xFFFFFFF9; with BOOTH_SKIP_ZERO_EN, out_valid 1 edge after accept.
- REQ-031 In DONE, hold out_ready=0 for 5 cycles while toggling in_valid and the operands -> product stable, in_ready=0, no new accept; out_ready=1 -> IDLE next edge.
- REQ-032 Pulse rst_n low at BUSY window 3 -> outputs cleared immediately; next accept A=2, B=-3 -> product=0xFFFFFFFA.
- REQ-033 Run 10k random operand pairs with random out_ready backpressure -> every product equals the signed reference model, in both macro builds.
